// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard / forwarding controller.
// Holds the forward-select encodings, the scoreboard entry type and small
// helper functions used by hazard_ctrl and hazard_fwd_sel.
package hazard_pkg;

    localparam int REG_AW   = 3;    // 8 architectural registers
    localparam int SB_DEPTH = 3;    // EX, MEM, WB; fixed

    // Scoreboard slot indices, youngest first
    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    // Operand forward selects, consumed by EX one cycle after ID computes them
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic              wr_en;
        logic [REG_AW-1:0] addr;
        logic              is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{wr_en: 1'b0, addr: 3'd0, is_load: 1'b0};

    // True when an in-flight producer writes the register an ID source reads.
    // Register 0 is an ordinary register here, so no zero-address exclusion.
    function automatic logic src_hit(input logic              wr_en,
                                     input logic [REG_AW-1:0] addr,
                                     input logic [REG_AW-1:0] rs,
                                     input logic              uses);
        return uses & wr_en & (addr == rs);
    endfunction

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: combinational forward-select for one ALU operand.
// Returns the stage of the youngest in-flight producer of rs_i, or the
// register file when no producer matches or the operand is not read.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] rs_i,
    input  logic              uses_i,
    input  sb_entry_t         ex_i,
    input  sb_entry_t         mem_i,
    input  sb_entry_t         wb_i,
    output logic [1:0]        sel_o
);

    // Load flags matter only for stall detection, not for forwarding
    logic unused_load_s;
    assign unused_load_s = ^{ex_i.is_load, mem_i.is_load, wb_i.is_load};

    // Youngest producer wins: EX over MEM over WB
    always_comb begin
        sel_o = FWD_RF;
        if (src_hit(ex_i.wr_en, ex_i.addr, rs_i, uses_i)) begin
            sel_o = FWD_EX;
        end else if (src_hit(mem_i.wr_en, mem_i.addr, rs_i, uses_i)) begin
            sel_o = FWD_MEM;
        end else if (src_hit(wb_i.wr_en, wb_i.addr, rs_i, uses_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for the 16-bit 5-stage core.
// Tracks in-flight destinations (EX/MEM/WB) to produce pipeline-register
// enables, bubble/flush controls and the two ALU forward selects. All outputs
// are combinational from the inputs and the registered state.
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cnt, freeze_cnt and
// flush_cnt saturating 16-bit counter outputs.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              mem_busy,
    input  logic              branch_taken,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              ctrl_regs_sel,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic [1:0]        alu_src_sel1,
    output logic [1:0]        alu_src_sel2
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       freeze_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    sb_entry_t  sb_q [SB_DEPTH];
    sb_entry_t  ex_d;
    logic       pend_q;
    logic       pend_d;
    logic [1:0] sel1_q;
    logic [1:0] sel2_q;
    logic [1:0] fwd1_s;
    logic [1:0] fwd2_s;
    logic       flush_s;
    logic       load_use_s;

    hazard_fwd_sel u_fwd_sel1 (
        .rs_i   (id_rs1),
        .uses_i (id_uses_rs1),
        .ex_i   (sb_q[SB_EX]),
        .mem_i  (sb_q[SB_MEM]),
        .wb_i   (sb_q[SB_WB]),
        .sel_o  (fwd1_s)
    );

    hazard_fwd_sel u_fwd_sel2 (
        .rs_i   (id_rs2),
        .uses_i (id_uses_rs2),
        .ex_i   (sb_q[SB_EX]),
        .mem_i  (sb_q[SB_MEM]),
        .wb_i   (sb_q[SB_WB]),
        .sel_o  (fwd2_s)
    );

    // Hazard detection: a pending (frozen-over) branch flushes like a live one
    always_comb begin
        flush_s    = branch_taken | pend_q;
        load_use_s = sb_q[SB_EX].is_load &
                     (src_hit(sb_q[SB_EX].wr_en, sb_q[SB_EX].addr, id_rs1, id_uses_rs1) |
                      src_hit(sb_q[SB_EX].wr_en, sb_q[SB_EX].addr, id_rs2, id_uses_rs2));
    end

    // Pipeline controls in priority order: reset, freeze, flush, load-use, normal
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        ctrl_regs_sel = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        alu_src_sel1  = fwd1_s;
        alu_src_sel2  = fwd2_s;
        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_en      = 1'b0;
            ctrl_regs_sel = 1'b1;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            alu_src_sel1  = FWD_RF;
            alu_src_sel2  = FWD_RF;
        end else if (mem_busy) begin
            // Whole pipe frozen; selects keep the value EX will still consume
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            alu_src_sel1  = sel1_q;
            alu_src_sel2  = sel2_q;
        end else if (flush_s) begin
            // Squash IF_ID and bubble ID_EX; a coincident load-use stall is moot
            if_id_flush   = 1'b1;
            ctrl_regs_sel = 1'b1;
        end else if (load_use_s) begin
            // Hold IF/ID one cycle; the load moves to MEM and forwards from there
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ctrl_regs_sel = 1'b1;
        end else begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            ctrl_regs_sel = 1'b0;
        end
    end

    // Next EX entry and pending-flush tracking
    always_comb begin
        if (ctrl_regs_sel || !id_valid) begin
            ex_d = SB_EMPTY;
        end else begin
            ex_d = '{wr_en: id_wr_en, addr: id_wr_addr, is_load: id_is_load};
        end
        if (mem_busy) begin
            pend_d = pend_q | branch_taken;
        end else begin
            pend_d = 1'b0;
        end
    end

    // Scoreboard shift, pending flag and held selects
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q[SB_EX]  <= SB_EMPTY;
            sb_q[SB_MEM] <= SB_EMPTY;
            sb_q[SB_WB]  <= SB_EMPTY;
            pend_q       <= 1'b0;
            sel1_q       <= FWD_RF;
            sel2_q       <= FWD_RF;
        end else begin
            if (id_ex_en) begin
                sb_q[SB_EX]  <= ex_d;
                sb_q[SB_MEM] <= sb_q[SB_EX];
                sb_q[SB_WB]  <= sb_q[SB_MEM];
            end else begin
                sb_q[SB_EX]  <= sb_q[SB_EX];
                sb_q[SB_MEM] <= sb_q[SB_MEM];
                sb_q[SB_WB]  <= sb_q[SB_WB];
            end
            pend_q <= pend_d;
            sel1_q <= alu_src_sel1;
            sel2_q <= alu_src_sel2;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] freeze_cnt_q;
    logic [15:0] flush_cnt_q;

    // Event counters: bubbles from load-use, frozen cycles, flushes applied
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= 16'd0;
            freeze_cnt_q <= 16'd0;
            flush_cnt_q  <= 16'd0;
        end else begin
            if (!mem_busy && !flush_s && load_use_s) begin
                stall_cnt_q <= sat_inc16(stall_cnt_q);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (mem_busy) begin
                freeze_cnt_q <= sat_inc16(freeze_cnt_q);
            end else begin
                freeze_cnt_q <= freeze_cnt_q;
            end
            if (!mem_busy && flush_s) begin
                flush_cnt_q <= sat_inc16(flush_cnt_q);
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan scenarios with literal expectations plus
// a randomized run compared every cycle against a behavioural model of the
// in-flight instruction list.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_wr_en, id_is_load;
    logic [2:0] id_rs1, id_rs2, id_wr_addr;
    logic       mem_busy, branch_taken;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, ctrl_regs_sel;
    logic       ex_mem_en, mem_wb_en;
    logic [1:0] alu_src_sel1, alu_src_sel2;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt, freeze_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_wr_en      (id_wr_en),
        .id_wr_addr    (id_wr_addr),
        .id_is_load    (id_is_load),
        .mem_busy      (mem_busy),
        .branch_taken  (branch_taken),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_en      (id_ex_en),
        .ctrl_regs_sel (ctrl_regs_sel),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_en     (mem_wb_en),
        .alu_src_sel1  (alu_src_sel1),
        .alu_src_sel2  (alu_src_sel2)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .freeze_cnt    (freeze_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // In-flight list: index 0 = EX (youngest), 1 = MEM, 2 = WB
    int m_wr   [3];
    int m_addr [3];
    int m_ld   [3];
    bit m_pend;
    int m_prev1, m_prev2;
    bit e_idex, e_bub;
    int e_s1, e_s2;

    function automatic int sel_of(input logic [2:0] rs, input logic uses);
        for (int i = 0; i < 3; i++) begin
            if (uses && m_wr[i] != 0 && m_addr[i] == int'(rs)) return i + 1;
        end
        return 0;
    endfunction

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin : cmp
        int  x_pc, x_ifen, x_fl, x_ide, x_bub, x_exm, x_mwb, x_s1, x_s2;
        bit  fc, fl, lu;
        x_s1 = sel_of(id_rs1, id_uses_rs1);
        x_s2 = sel_of(id_rs2, id_uses_rs2);
        fc = 1'b1;
        if (rst) begin
            x_pc = 0; x_ifen = 0; x_ide = 0; x_exm = 0; x_mwb = 0;
            x_fl = 1; x_bub = 1; x_s1 = 0; x_s2 = 0;
        end else if (mem_busy) begin
            x_pc = 0; x_ifen = 0; x_ide = 0; x_exm = 0; x_mwb = 0;
            x_fl = 0; x_bub = 0; x_s1 = m_prev1; x_s2 = m_prev2;
            fc = 1'b0;
        end else begin
            fl = branch_taken || m_pend;
            lu = m_wr[0] != 0 && m_ld[0] != 0 &&
                 ((id_uses_rs1 && m_addr[0] == int'(id_rs1)) ||
                  (id_uses_rs2 && m_addr[0] == int'(id_rs2)));
            x_ide = 1; x_exm = 1; x_mwb = 1;
            x_fl  = fl ? 1 : 0;
            x_bub = (fl || lu) ? 1 : 0;
            x_pc  = (!fl && lu) ? 0 : 1;
            x_ifen = x_pc;
        end
        chk("pc_en",        8'(pc_en),        8'(x_pc));
        chk("if_id_en",     8'(if_id_en),     8'(x_ifen));
        chk("id_ex_en",     8'(id_ex_en),     8'(x_ide));
        chk("ex_mem_en",    8'(ex_mem_en),    8'(x_exm));
        chk("mem_wb_en",    8'(mem_wb_en),    8'(x_mwb));
        chk("alu_src_sel1", 8'(alu_src_sel1), 8'(x_s1));
        chk("alu_src_sel2", 8'(alu_src_sel2), 8'(x_s2));
        if (fc) begin
            chk("if_id_flush",   8'(if_id_flush),   8'(x_fl));
            chk("ctrl_regs_sel", 8'(ctrl_regs_sel), 8'(x_bub));
        end
        e_idex <= (x_ide != 0);
        e_bub  <= (x_bub != 0);
        e_s1   <= x_s1;
        e_s2   <= x_s2;
    end

    // Model state update on the active edge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_wr[i] <= 0; m_addr[i] <= 0; m_ld[i] <= 0;
            end
            m_pend <= 1'b0; m_prev1 <= 0; m_prev2 <= 0;
        end else begin
            if (e_idex) begin
                m_wr[2] <= m_wr[1]; m_addr[2] <= m_addr[1]; m_ld[2] <= m_ld[1];
                m_wr[1] <= m_wr[0]; m_addr[1] <= m_addr[0]; m_ld[1] <= m_ld[0];
                if (e_bub || !id_valid) begin
                    m_wr[0] <= 0; m_addr[0] <= 0; m_ld[0] <= 0;
                end else begin
                    m_wr[0] <= int'(id_wr_en); m_addr[0] <= int'(id_wr_addr); m_ld[0] <= int'(id_is_load);
                end
            end
            m_prev1 <= e_s1;
            m_prev2 <= e_s2;
            m_pend  <= mem_busy ? (m_pend || branch_taken) : 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] r1, input logic u1,
                       input logic [2:0] r2, input logic u2,
                       input logic we, input logic [2:0] wa, input logic ld);
        id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
        id_wr_en = we; id_wr_addr = wa; id_is_load = ld;
    endtask

    initial begin
        rst = 1'b1; mem_busy = 1'b0; branch_taken = 1'b0;
        drv(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("rst pc_en", 8'(pc_en), 8'd0);
        chk("rst if_id_flush", 8'(if_id_flush), 8'd1);
        chk("rst ctrl_regs_sel", 8'(ctrl_regs_sel), 8'd1);
        chk("rst mem_wb_en", 8'(mem_wb_en), 8'd0);
        nxt(); nxt();
        rst = 1'b0;

        // ADD r1 then ADD reading r1 as rs1: EX forward, no stall
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0); nxt();
        drv(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("raw sel1", 8'(alu_src_sel1), 8'd1);
        chk("raw pc_en", 8'(pc_en), 8'd1);
        chk("raw ctrl_regs_sel", 8'(ctrl_regs_sel), 8'd0);
        nxt();

        // Load r2 then ADD reading r2 as rs2: one bubble, then MEM forward
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1); nxt();
        drv(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("lu pc_en", 8'(pc_en), 8'd0);
        chk("lu if_id_en", 8'(if_id_en), 8'd0);
        chk("lu ctrl_regs_sel", 8'(ctrl_regs_sel), 8'd1);
        chk("lu id_ex_en", 8'(id_ex_en), 8'd1);
        nxt();
        @(negedge clk);
        chk("lu+1 pc_en", 8'(pc_en), 8'd1);
        chk("lu+1 ctrl_regs_sel", 8'(ctrl_regs_sel), 8'd0);
        chk("lu+1 sel2", 8'(alu_src_sel2), 8'd2);
        nxt();

        // Producers of r3 in EX, MEM and WB: youngest wins
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0); nxt();
        end
        drv(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("young sel1", 8'(alu_src_sel1), 8'd1);
        chk("young sel2", 8'(alu_src_sel2), 8'd1);
        nxt();

        // Freeze for 3 cycles with a branch in cycle 2, then one flush
        drv(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        nxt(); nxt(); nxt();
        mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            branch_taken = (c == 1);
            @(negedge clk);
            chk("frz pc_en", 8'(pc_en), 8'd0);
            chk("frz if_id_en", 8'(if_id_en), 8'd0);
            chk("frz id_ex_en", 8'(id_ex_en), 8'd0);
            chk("frz ex_mem_en", 8'(ex_mem_en), 8'd0);
            chk("frz mem_wb_en", 8'(mem_wb_en), 8'd0);
            nxt();
        end
        mem_busy = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        chk("pend if_id_flush", 8'(if_id_flush), 8'd1);
        chk("pend ctrl_regs_sel", 8'(ctrl_regs_sel), 8'd1);
        chk("pend pc_en", 8'(pc_en), 8'd1);
        nxt();
        @(negedge clk);
        chk("pend+1 if_id_flush", 8'(if_id_flush), 8'd0);
        nxt();

        // Load-use and taken branch together: flush wins
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1); nxt();
        drv(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        branch_taken = 1'b1;
        @(negedge clk);
        chk("lu+br if_id_flush", 8'(if_id_flush), 8'd1);
        chk("lu+br pc_en", 8'(pc_en), 8'd1);
        chk("lu+br ctrl_regs_sel", 8'(ctrl_regs_sel), 8'd1);
        nxt();
        branch_taken = 1'b0;
        nxt();

        // Reset for one cycle in the middle of a load-use stall
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1); nxt();
        drv(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("rs-stall pc_en", 8'(pc_en), 8'd0);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("rs pc_en", 8'(pc_en), 8'd0);
        chk("rs if_id_flush", 8'(if_id_flush), 8'd1);
        chk("rs sel1", 8'(alu_src_sel1), 8'd0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rs+1 sel1", 8'(alu_src_sel1), 8'd0);
        chk("rs+1 pc_en", 8'(pc_en), 8'd1);
        nxt();

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            mem_busy     = ($urandom_range(0, 99) < 15);
            branch_taken = ($urandom_range(0, 99) < 8);
            drv(($urandom_range(0, 9) != 0),
                3'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0),
                ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 35));
            nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
